// File: rtl/uc_multiciclo_hs.sv
// ---------------------------------------------------------------------------
// uc_multiciclo_hs
// Multicycle control unit for the RV64 datapath with a ready handshake to the
// instruction/data memory, a bounded wait timeout, a sticky error state and
// branch/JAL PC-source selection.
//
// States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 ERR=5.
// Datapath control outputs are decoded from the current state (plus
// mem_ready/flag where the handshake or branch needs it). While reset is high
// every write enable, instr_done and pc_src are held low.
//
// Optional build macro: UC_PERF_CNT_EN
//   defined   -> adds retired[31:0] and stall_cyc[31:0] performance counters
//   undefined -> counters and their ports are absent
// ---------------------------------------------------------------------------
module uc_multiciclo_hs #(
    parameter int unsigned STATE_W      = 4,
    parameter int unsigned WAIT_TIMEOUT = 15,
    parameter int unsigned CNT_W        = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               flag,
    input  logic               mem_ready,
    output logic [STATE_W-1:0] state,
    output logic [1:0]         aluop,
    output logic               mux1,
    output logic [1:0]         mux2,
    output logic               mux4,
    output logic               pc_src,
    output logic               we_mem,
    output logic               we_reg,
    output logic               we_ir,
    output logic               we_pc,
    output logic               error,
    output logic               instr_done
`ifdef UC_PERF_CNT_EN
    ,
    output logic [31:0]        retired,
    output logic [31:0]        stall_cyc
`endif
);

    // State encodings
    localparam logic [STATE_W-1:0] ST_FETCH  = STATE_W'(0);
    localparam logic [STATE_W-1:0] ST_DECODE = STATE_W'(1);
    localparam logic [STATE_W-1:0] ST_EXEC   = STATE_W'(2);
    localparam logic [STATE_W-1:0] ST_MEM    = STATE_W'(3);
    localparam logic [STATE_W-1:0] ST_WB     = STATE_W'(4);
    localparam logic [STATE_W-1:0] ST_ERR    = STATE_W'(5);

    // Supported opcodes
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // ALU operation codes towards ALUControl
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BRCMP = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Register write-data select
    localparam logic [1:0] WD_MEM   = 2'b00;
    localparam logic [1:0] WD_ALU   = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    // Wait-counter limits
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(WAIT_TIMEOUT);
    localparam bit               TIMEOUT_EN  = (WAIT_TIMEOUT != 0);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               error_q, error_d;

    logic               waiting_c;
    logic               timeout_c;

    // A memory wait is a not-ready cycle in FETCH or MEM; timeout fires at the limit
    always_comb begin
        waiting_c = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
        timeout_c = TIMEOUT_EN && waiting_c && (cnt_q == TIMEOUT_VAL);
    end

    // Next-state, wait counter and sticky error computation
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        error_d = error_q;

        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_R, OP_LD, OP_SD, OP_B, OP_JAL: state_d = ST_EXEC;
                    default:                          state_d = ST_ERR;
                endcase
            end
            ST_EXEC: begin
                case (opcode)
                    OP_R:        state_d = ST_WB;
                    OP_LD, OP_SD: state_d = ST_MEM;
                    OP_B, OP_JAL: state_d = ST_FETCH;
                    default:     state_d = ST_ERR;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    case (opcode)
                        OP_LD:   state_d = ST_WB;
                        OP_SD:   state_d = ST_FETCH;
                        default: state_d = ST_ERR;
                    endcase
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_ERR: begin
                state_d = ST_ERR;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase

        // Saturating count of consecutive not-ready cycles
        if (waiting_c) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end

        if (timeout_c) begin
            state_d = ST_ERR;
            cnt_d   = cnt_q;
        end

        if (state_d == ST_ERR) begin
            error_d = 1'b1;
        end
    end

    // State, wait counter and error flops with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    // Datapath control decode from the current state
    always_comb begin
        aluop      = ALU_ADD;
        mux1       = 1'b0;
        mux2       = WD_MEM;
        mux4       = 1'b0;
        pc_src     = 1'b0;
        we_mem     = 1'b0;
        we_reg     = 1'b0;
        we_ir      = 1'b0;
        we_pc      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                we_ir = mem_ready;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_R: begin
                        aluop = ALU_FUNCT;
                    end
                    OP_LD, OP_SD: begin
                        aluop = ALU_ADD;
                        mux1  = 1'b1;
                    end
                    OP_B: begin
                        aluop  = ALU_BRCMP;
                        mux4   = 1'b1;
                        pc_src = flag;
                        we_pc  = 1'b1;
                    end
                    OP_JAL: begin
                        mux4   = 1'b1;
                        mux2   = WD_PC4;
                        we_reg = 1'b1;
                        pc_src = 1'b1;
                        we_pc  = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            ST_MEM: begin
                // Address operands held for the whole memory stay
                aluop = ALU_ADD;
                mux1  = 1'b1;
                if (opcode == OP_SD) begin
                    we_mem = 1'b1;
                    we_pc  = mem_ready;
                end
            end
            ST_WB: begin
                mux2   = (opcode == OP_LD) ? WD_MEM : WD_ALU;
                we_reg = 1'b1;
                we_pc  = 1'b1;
            end
            default: begin
            end
        endcase

        // A timed-out access commits nothing
        if (timeout_c) begin
            we_mem = 1'b0;
            we_reg = 1'b0;
            we_ir  = 1'b0;
            we_pc  = 1'b0;
            pc_src = 1'b0;
        end

        // No architectural write while reset is being sampled
        if (reset) begin
            we_mem = 1'b0;
            we_reg = 1'b0;
            we_ir  = 1'b0;
            we_pc  = 1'b0;
            pc_src = 1'b0;
        end

        instr_done = we_pc;
    end

    // Status outputs straight from the flops
    always_comb begin
        state = state_q;
        error = error_q;
    end

`ifdef UC_PERF_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic [31:0] stall_q, stall_d;

    // Retired-instruction and stall-cycle counters, wrapping at 2^32
    always_comb begin
        retired_d = retired_q + (instr_done ? 32'd1 : 32'd0);
        stall_d   = stall_q + (waiting_c ? 32'd1 : 32'd0);
    end

    // Performance counter flops
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            retired_q <= retired_d;
            stall_q   <= stall_d;
        end
    end

    // Counter outputs
    always_comb begin
        retired   = retired_q;
        stall_cyc = stall_q;
    end
`endif

endmodule
